// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM capture block
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE
    } state_t;

    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;
    localparam int DIV_LAT   = 8;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM capture control/measurement bundle
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic              pwm_in;
    logic              enable;
    logic              meas_valid;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              duty_valid;
    logic [DUTY_W-1:0] duty_pct;
    logic              stuck_high;
    logic              stuck_low;

    modport master (
        output pwm_in, enable,
        input  meas_valid, high_cnt, period_cnt, duty_valid, duty_pct,
               stuck_high, stuck_low
    );

    modport slave (
        input  pwm_in, enable,
        output meas_valid, high_cnt, period_cnt, duty_valid, duty_pct,
               stuck_high, stuck_low
    );

endinterface

// File: rtl/pwm_duty_div.sv
// rtl/pwm_duty_div.sv - restoring divider giving floor(high*100/period), one quotient bit per cycle
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_high,
    input  logic [CNT_W-1:0]  i_period,
    output logic              o_busy,
    output logic              o_done,
    output logic [DUTY_W-1:0] o_quot
);

    localparam int NUM_W = CNT_W + DUTY_W;

    logic              r_busy;
    logic              r_done;
    logic [NUM_W-1:0]  r_rem;
    logic [NUM_W-1:0]  r_dsh;
    logic [DUTY_W-1:0] r_q;
    logic [DUTY_W-1:0] r_quot;
    logic [2:0]        r_step;

    logic [NUM_W-1:0]  w_num;
    logic              w_ge;

    assign w_num  = NUM_W'(i_high) * NUM_W'(PCT_SCALE);
    assign w_ge   = (r_rem >= r_dsh);
    // done counts as busy so a start landing on the result cycle is dropped
    assign o_busy = r_busy | r_done;
    assign o_done = r_done;
    assign o_quot = r_quot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_rem  <= '0;
            r_dsh  <= '0;
            r_q    <= '0;
            r_quot <= '0;
            r_step <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !o_busy) begin
                r_rem  <= w_num;
                r_dsh  <= NUM_W'(i_period) << (DUTY_W - 1);
                r_q    <= '0;
                r_step <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (w_ge) begin
                    r_rem <= r_rem - r_dsh;
                end
                r_dsh  <= r_dsh >> 1;
                r_q    <= {r_q[DUTY_W-2:0], w_ge};
                r_step <= r_step + 3'd1;
                if (r_step == 3'(DUTY_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_quot <= {r_q[DUTY_W-2:0], w_ge};
                end
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period monitor with duty percentage and stuck-line detection
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst,
    pwm_capture_if.slave bus
);

    localparam int         TMO_W   = $clog2(TIMEOUT + 1);
    localparam [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_sync1, r_sync2, r_dly;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, r_hi_lat, r_high, r_period;
    logic [TMO_W-1:0] r_tmo;
    logic             r_meas_valid, r_stuck_high, r_stuck_low;

    logic             w_rise, w_fall, w_run, w_tmo_hit, w_meas_fire;
    logic             w_div_busy;

    assign w_rise      = r_sync2 & ~r_dly;
    assign w_fall      = ~r_sync2 & r_dly;
    assign w_run       = bus.enable && (r_state != ST_IDLE);
    // a rise or fall in the same cycle restarts the window, so edges win over timeout
    assign w_tmo_hit   = w_run && !w_rise && !w_fall && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_meas_fire = w_run && (r_state == ST_MEASURE) && w_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.enable) w_next = ST_ARM;
            ST_ARM:     if (w_rise)     w_next = ST_MEASURE;
            ST_MEASURE: if (w_tmo_hit)  w_next = ST_ARM;
            default:                    w_next = ST_IDLE;
        endcase
        if (!bus.enable) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_hi_lat     <= '0;
            r_high       <= '0;
            r_period     <= '0;
            r_tmo        <= '0;
            r_meas_valid <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_meas_valid <= w_meas_fire;
            if (!w_run) begin
                r_cnt <= '0;
                r_tmo <= '0;
                if (r_state == ST_IDLE) begin
                    r_stuck_high <= 1'b0;
                    r_stuck_low  <= 1'b0;
                end
            end else begin
                if (w_rise || w_fall || w_tmo_hit) begin
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end

                if (w_rise) begin
                    r_stuck_high <= 1'b0;
                    r_stuck_low  <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_stuck_high <= r_sync2;
                    r_stuck_low  <= ~r_sync2;
                end

                // ARM never accumulates, so a partial period cannot leak into a result
                if (w_rise) begin
                    r_cnt    <= CNT_W'(1);
                    r_hi_lat <= '0;
                end else if (r_state != ST_MEASURE || w_tmo_hit) begin
                    r_cnt <= '0;
                end else if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end

                if (w_fall && r_state == ST_MEASURE) begin
                    r_hi_lat <= r_cnt;
                end

                if (w_meas_fire) begin
                    r_period <= r_cnt;
                    r_high   <= r_hi_lat;
                end
            end
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (r_meas_valid),
        .i_high   (r_high),
        .i_period (r_period),
        .o_busy   (w_div_busy),
        .o_done   (bus.duty_valid),
        .o_quot   (bus.duty_pct)
    );

    assign bus.meas_valid = r_meas_valid;
    assign bus.high_cnt   = r_high;
    assign bus.period_cnt = r_period;
    assign bus.stuck_high = r_stuck_high;
    assign bus.stuck_low  = r_stuck_low;

    logic w_unused;
    assign w_unused = w_div_busy;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed vector bench for pwm_capture
module tb_pwm_capture
    import pwm_pkg::*;
;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_W(16)) u_if ();

    pwm_capture #(
        .CNT_W   (16),
        .TIMEOUT (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_hi;
        int exp_per;
        int exp_duty;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_err    = 0;

    int hq[$];
    int pq[$];
    int dq[$];
    int lat_bad = 0;
    logic [7:0] mv_hist = '0;

    always @(negedge clk) begin
        if (u_if.duty_valid && !mv_hist[DIV_LAT-1]) lat_bad = lat_bad + 1;
        mv_hist <= {mv_hist[6:0], u_if.meas_valid};
        if (u_if.meas_valid) begin
            hq.push_back(int'(u_if.high_cnt));
            pq.push_back(int'(u_if.period_cnt));
        end
        if (u_if.duty_valid) dq.push_back(int'(u_if.duty_pct));
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_pwm(input int hi, input int lo);
        u_if.pwm_in = 1'b1;
        cyc(hi);
        u_if.pwm_in = 1'b0;
        cyc(lo);
    endtask

    task automatic rearm();
        u_if.enable = 1'b0;
        u_if.pwm_in = 1'b0;
        cyc(5);
        u_if.enable = 1'b1;
        cyc(5);
    endtask

    function automatic int last_of(input int q[$], input int base);
        if (q.size() > base) return q[q.size()-1];
        return -1;
    endfunction

    initial begin
        int mb, db, got;

        vecs[0] = '{hi: 30, lo: 70, n: 3, exp_hi: 30, exp_per: 100, exp_duty: 30};
        vecs[1] = '{hi:  1, lo:  2, n: 6, exp_hi:  1, exp_per:   3, exp_duty: 33};
        vecs[2] = '{hi: 50, lo: 50, n: 3, exp_hi: 50, exp_per: 100, exp_duty: 50};
        vecs[3] = '{hi:  7, lo: 13, n: 4, exp_hi:  7, exp_per:  20, exp_duty: 35};
        vecs[4] = '{hi: 99, lo:  1, n: 3, exp_hi: 99, exp_per: 100, exp_duty: 99};
        vecs[5] = '{hi:  1, lo: 99, n: 3, exp_hi:  1, exp_per: 100, exp_duty:  1};
        vecs[6] = '{hi:  2, lo:  7, n: 4, exp_hi:  2, exp_per:   9, exp_duty: 22};

        u_if.pwm_in = 1'b0;
        u_if.enable = 1'b0;
        cyc(3);
        check("rst_meas_valid", int'(u_if.meas_valid), 0);
        check("rst_high_cnt",   int'(u_if.high_cnt),   0);
        check("rst_period_cnt", int'(u_if.period_cnt), 0);
        check("rst_duty_valid", int'(u_if.duty_valid), 0);
        check("rst_duty_pct",   int'(u_if.duty_pct),   0);
        check("rst_stuck_high", int'(u_if.stuck_high), 0);
        check("rst_stuck_low",  int'(u_if.stuck_low),  0);
        rst = 1'b1;
        cyc(2);

        for (int v = 0; v < 7; v++) begin
            rearm();
            mb = hq.size();
            for (int p = 0; p < vecs[v].n; p++) run_pwm(vecs[v].hi, vecs[v].lo);
            cyc(20);
            check($sformatf("vec%0d_meas_count", v), hq.size() - mb, vecs[v].n - 1);
            check($sformatf("vec%0d_high_cnt", v),   last_of(hq, mb), vecs[v].exp_hi);
            check($sformatf("vec%0d_period_cnt", v), last_of(pq, mb), vecs[v].exp_per);
            check($sformatf("vec%0d_duty_pct", v),   int'(u_if.duty_pct), vecs[v].exp_duty);
        end

        // ramp: ton grows by 5 each 100-cycle period
        rearm();
        mb = hq.size();
        db = dq.size();
        for (int k = 1; k <= 10; k++) run_pwm(5 * k, 100 - 5 * k);
        run_pwm(5, 20);
        check("ramp_meas_count", hq.size() - mb, 10);
        for (int k = 0; k < 10; k++)
            check($sformatf("ramp_duty%0d", k), (dq.size() > db + k) ? dq[db + k] : -1, 5 * (k + 1));

        // stuck low, then recovery
        rearm();
        for (int p = 0; p < 3; p++) run_pwm(50, 50);
        cyc(900);
        check("stuck_low_early", int'(u_if.stuck_low), 0);
        cyc(100);
        check("stuck_low_set", int'(u_if.stuck_low), 1);
        check("stuck_low_no_high", int'(u_if.stuck_high), 0);
        mb = hq.size();
        u_if.pwm_in = 1'b1;
        cyc(10);
        check("stuck_low_cleared", int'(u_if.stuck_low), 0);
        u_if.pwm_in = 1'b1;
        cyc(40);
        u_if.pwm_in = 1'b0;
        cyc(50);
        for (int p = 0; p < 2; p++) run_pwm(50, 50);
        cyc(5);
        check("resume_meas_count", hq.size() - mb, 2);
        check("resume_high_cnt",   last_of(hq, mb), 50);
        check("resume_period_cnt", last_of(pq, mb), 100);

        // stuck high
        u_if.pwm_in = 1'b1;
        cyc(900);
        check("stuck_high_early", int'(u_if.stuck_high), 0);
        cyc(200);
        check("stuck_high_set", int'(u_if.stuck_high), 1);
        check("stuck_high_no_low", int'(u_if.stuck_low), 0);
        u_if.pwm_in = 1'b0;

        // enable dropped mid-period
        rearm();
        for (int p = 0; p < 2; p++) run_pwm(50, 50);
        u_if.pwm_in = 1'b1;
        cyc(5);
        mb = hq.size();
        cyc(15);
        u_if.enable = 1'b0;
        cyc(5);
        u_if.enable = 1'b1;
        cyc(10);
        u_if.pwm_in = 1'b0;
        cyc(50);
        for (int p = 0; p < 2; p++) run_pwm(40, 60);
        cyc(5);
        check("en_drop_meas_count", hq.size() - mb, 1);
        check("en_drop_high_cnt",   last_of(hq, mb), 40);
        check("en_drop_period_cnt", last_of(pq, mb), 100);

        // async reset mid-division
        rearm();
        run_pwm(30, 70);
        mb = hq.size();
        u_if.pwm_in = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            cyc(1);
            if (hq.size() > mb) got = 1;
        end
        check("rstmid_meas_seen", got, 1);
        cyc(3);
        #2 rst = 1'b0;
        #1;
        check("rstmid_high_cnt",   int'(u_if.high_cnt),   0);
        check("rstmid_period_cnt", int'(u_if.period_cnt), 0);
        check("rstmid_duty_pct",   int'(u_if.duty_pct),   0);
        check("rstmid_meas_valid", int'(u_if.meas_valid), 0);
        check("rstmid_stuck_high", int'(u_if.stuck_high), 0);
        db = dq.size();
        u_if.pwm_in = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(15);
        check("rstmid_no_duty", dq.size() - db, 0);
        mb = hq.size();
        for (int p = 0; p < 3; p++) run_pwm(30, 70);
        cyc(20);
        check("post_rst_meas_count", hq.size() - mb, 2);
        check("post_rst_high_cnt",   last_of(hq, mb), 30);
        check("post_rst_period_cnt", last_of(pq, mb), 100);
        check("post_rst_duty_pct",   int'(u_if.duty_pct), 30);

        check("duty_latency", lat_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
